// File: rtl/fpu_operand_unpacker_if.sv
// Handshake and data bundle between the FPU issue side, the operand unpacker and the datapaths.
interface fpu_operand_unpacker_if #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23
);
  localparam int W = 1 + EXP_WIDTH + FRAC_WIDTH;

  logic                  in_valid;
  logic                  in_ready;
  logic [W-1:0]          a;
  logic [W-1:0]          b;
  logic                  out_valid;
  logic                  out_ready;
  logic                  a_sign;
  logic                  b_sign;
  logic [EXP_WIDTH+1:0]  a_exponent;
  logic [EXP_WIDTH+1:0]  b_exponent;
  logic [FRAC_WIDTH:0]   a_significand;
  logic [FRAC_WIDTH:0]   b_significand;
  logic [2:0]            a_type;
  logic [2:0]            b_type;
  logic                  a_snan;
  logic                  b_snan;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, a_sign, b_sign, a_exponent, b_exponent,
           a_significand, b_significand, a_type, b_type, a_snan, b_snan
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, a_sign, b_sign, a_exponent, b_exponent,
           a_significand, b_significand, a_type, b_type, a_snan, b_snan
  );
endinterface

// File: rtl/fpu_operand_unpacker.sv
// Splits IEEE-754 operands A/B into sign, extended exponent, normalized significand and class.
// Latency 2 cycles, one pair per cycle; elastic valid/ready stages stall without bubbles.
module fpu_operand_unpacker #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23
) (
  input  logic                   clk,
  input  logic                   reset_n,
  fpu_operand_unpacker_if.slave  bus
);
  localparam int W   = 1 + EXP_WIDTH + FRAC_WIDTH;
  localparam int XW  = EXP_WIDTH + 2;
  localparam int LZW = $clog2(FRAC_WIDTH + 1);

  typedef enum logic [2:0] {
    NORMAL    = 3'b000,
    NAN       = 3'b010,
    INFINITE  = 3'b011,
    SUBNORMAL = 3'b100,
    ZERO      = 3'b101
  } operand_type;

  typedef struct packed {
    logic                  sign;
    logic [EXP_WIDTH-1:0]  exp;
    logic [FRAC_WIDTH-1:0] frac;
    operand_type           kind;
    logic                  snan;
    logic [LZW-1:0]        lz;
  } s1_t;

  typedef struct packed {
    logic                  sign;
    logic [XW-1:0]         exponent;
    logic [FRAC_WIDTH:0]   significand;
    operand_type           kind;
    logic                  snan;
  } s2_t;

  // Leading zeros of {1'b0,f}; the highest set bit wins because it is assigned last.
  function automatic logic [LZW-1:0] lzc(input logic [FRAC_WIDTH-1:0] f);
    logic [LZW-1:0] n;
    n = LZW'(FRAC_WIDTH);
    for (int i = 0; i < FRAC_WIDTH; i++) begin
      if (f[i]) n = LZW'(FRAC_WIDTH - i);
    end
    return n;
  endfunction

  function automatic s1_t classify(input logic [W-1:0] x);
    s1_t  r;
    logic e_zero, e_ones, f_zero;
    r.sign = x[W-1];
    r.exp  = x[W-2 -: EXP_WIDTH];
    r.frac = x[FRAC_WIDTH-1:0];
    r.lz   = '0;
    r.snan = 1'b0;
    e_zero = (r.exp == '0);
    e_ones = &r.exp;
    f_zero = (r.frac == '0);
    if (e_zero && f_zero) begin
      r.kind = ZERO;
    end else if (e_zero) begin
      r.kind = SUBNORMAL;
      r.lz   = lzc(r.frac);
    end else if (e_ones && f_zero) begin
      r.kind = INFINITE;
    end else if (e_ones) begin
      r.kind = NAN;
      r.snan = !r.frac[FRAC_WIDTH-1];
    end else begin
      r.kind = NORMAL;
    end
    return r;
  endfunction

  function automatic s2_t expand(input s1_t p);
    s2_t r;
    r.sign = p.sign;
    r.kind = p.kind;
    r.snan = p.snan;
    case (p.kind)
      SUBNORMAL: begin
        // Two's-complement exponent 1-lz keeps the value exact after normalization.
        r.exponent    = XW'(1) - XW'(p.lz);
        r.significand = {1'b0, p.frac} << p.lz;
      end
      ZERO: begin
        r.exponent    = '0;
        r.significand = '0;
      end
      INFINITE, NAN: begin
        r.exponent    = XW'(p.exp);
        r.significand = {1'b0, p.frac};
      end
      default: begin
        r.exponent    = XW'(p.exp);
        r.significand = {1'b1, p.frac};
      end
    endcase
    return r;
  endfunction

  logic s1_valid, s2_valid;
  logic s1_en, s2_en;
  s1_t  s1_a, s1_b;
  s2_t  s2_a, s2_b;

  assign s2_en       = !s2_valid || bus.out_ready;
  assign s1_en       = !s1_valid || s2_en;
  assign bus.in_ready = s1_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_en) s1_valid <= bus.in_valid;
      if (s2_en) s2_valid <= s1_valid;
    end
  end

  // Data only moves with a valid token so idle-cycle inputs never reach the outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_a <= '0;
      s1_b <= '0;
      s2_a <= '0;
      s2_b <= '0;
    end else begin
      if (s1_en && bus.in_valid) begin
        s1_a <= classify(bus.a);
        s1_b <= classify(bus.b);
      end
      if (s2_en && s1_valid) begin
        s2_a <= expand(s1_a);
        s2_b <= expand(s1_b);
      end
    end
  end

  assign bus.out_valid     = s2_valid;
  assign bus.a_sign        = s2_a.sign;
  assign bus.b_sign        = s2_b.sign;
  assign bus.a_exponent    = s2_a.exponent;
  assign bus.b_exponent    = s2_b.exponent;
  assign bus.a_significand = s2_a.significand;
  assign bus.b_significand = s2_b.significand;
  assign bus.a_type        = s2_a.kind;
  assign bus.b_type        = s2_b.kind;
  assign bus.a_snan        = s2_a.snan;
  assign bus.b_snan        = s2_b.snan;
endmodule

// File: tb/tb_fpu_operand_unpacker.sv
// Randomized and directed bench for fpu_operand_unpacker against an arithmetic reference model.
module tb_fpu_operand_unpacker;
  typedef struct packed {
    logic        sign;
    logic [9:0]  exponent;
    logic [23:0] significand;
    logic [2:0]  kind;
    logic        snan;
  } op_t;

  typedef struct {
    int  cyc;
    op_t a;
    op_t b;
  } pair_t;

  logic  clk = 1'b0;
  logic  reset_n;
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  pair_t q[$];

  fpu_operand_unpacker_if #(.EXP_WIDTH(8), .FRAC_WIDTH(23)) bus ();

  fpu_operand_unpacker #(.EXP_WIDTH(8), .FRAC_WIDTH(23)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic op_t mk(input logic s, input logic [9:0] e, input logic [23:0] m,
                             input logic [2:0] t, input logic sn);
    return {s, e, m, t, sn};
  endfunction

  // Value-level model: subnormals are normalized by doubling until the hidden bit appears.
  function automatic op_t ref_op(input logic [31:0] x);
    op_t         r;
    logic [7:0]  e;
    logic [22:0] f;
    int          ex;
    int unsigned m;
    e = x[30:23];
    f = x[22:0];
    r.sign = x[31];
    r.snan = 1'b0;
    if (e == 8'hFF) begin
      r.kind        = (f != 0) ? 3'b010 : 3'b011;
      r.exponent    = 10'd255;
      r.significand = {1'b0, f};
      r.snan        = (f != 0) && (f < 23'h400000);
    end else if (e == 0 && f == 0) begin
      r.kind        = 3'b101;
      r.exponent    = 10'd0;
      r.significand = 24'd0;
    end else if (e == 0) begin
      ex = 1;
      m  = 32'(f);
      while (m < 32'h800000) begin
        m  = m * 2;
        ex = ex - 1;
      end
      r.kind        = 3'b100;
      r.exponent    = 10'(ex);
      r.significand = 24'(m);
    end else begin
      r.kind        = 3'b000;
      r.exponent    = 10'(32'(e));
      r.significand = 24'(32'(f) + 32'h800000);
    end
    return r;
  endfunction

  function automatic op_t got_a();
    return {bus.a_sign, bus.a_exponent, bus.a_significand, bus.a_type, bus.a_snan};
  endfunction

  function automatic op_t got_b();
    return {bus.b_sign, bus.b_exponent, bus.b_significand, bus.b_type, bus.b_snan};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] f;
    case ($urandom_range(0, 5))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      default: e = 8'($urandom);
    endcase
    case ($urandom_range(0, 3))
      0:       f = 23'd0;
      1:       f = 23'($urandom_range(0, 15));
      default: f = 23'($urandom);
    endcase
    return {1'($urandom), e, f};
  endfunction

  // Occupancy and age rules: full only with two pairs in flight; a pair shows two cycles after offer.
  always @(negedge clk) begin
    if (reset_n) begin : cmp
      logic er, ev;
      er = (q.size() < 2) || bus.out_ready;
      ev = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
      chk("in_ready", 64'(bus.in_ready), 64'(er));
      chk("out_valid", 64'(bus.out_valid), 64'(ev));
      if (ev && bus.out_valid) begin
        chk("out_a", 64'(got_a()), 64'(q[0].a));
        chk("out_b", 64'(got_b()), 64'(q[0].b));
      end
      if (bus.out_valid && bus.out_ready && q.size() > 0) void'(q.pop_front());
      if (bus.in_valid && bus.in_ready) q.push_back('{cyc: cyc, a: ref_op(bus.a), b: ref_op(bus.b)});
    end
  end

  task automatic directed(input string name, input logic [31:0] va, input logic [31:0] vb,
                          input op_t ea, input op_t eb);
    bus.in_valid = 1'b1;
    bus.a        = va;
    bus.b        = vb;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    chk({name, "_lat1"}, 64'(bus.out_valid), 64'(0));
    @(posedge clk);
    #1;
    chk({name, "_lat2"}, 64'(bus.out_valid), 64'(1));
    chk({name, "_a"}, 64'(got_a()), 64'(ea));
    chk({name, "_b"}, 64'(got_b()), 64'(eb));
  endtask

  logic [31:0] pa [4];
  logic [31:0] pb [4];
  int          sent;
  logic        saw_block;
  logic        hold;

  initial begin
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_a", 64'(got_a()), 64'(0));
    chk("rst_b", 64'(got_b()), 64'(0));
    reset_n = 1'b1;

    chk("model_norm", 64'(ref_op(32'h3F800000)), 64'(mk(1'b0, 10'd127, 24'h800000, 3'b000, 1'b0)));
    chk("model_sub1", 64'(ref_op(32'h00000001)), 64'(mk(1'b0, 10'h3EA, 24'h800000, 3'b100, 1'b0)));
    chk("model_snan", 64'(ref_op(32'h7F800001)), 64'(mk(1'b0, 10'd255, 24'h000001, 3'b010, 1'b1)));

    @(posedge clk);
    #1;
    directed("t1", 32'h3F800000, 32'h00000001,
             mk(1'b0, 10'd127, 24'h800000, 3'b000, 1'b0), mk(1'b0, 10'h3EA, 24'h800000, 3'b100, 1'b0));
    directed("t2", 32'h80000000, 32'h007FFFFF,
             mk(1'b1, 10'd0, 24'h000000, 3'b101, 1'b0), mk(1'b0, 10'd0, 24'hFFFFFE, 3'b100, 1'b0));
    directed("t3", 32'h7F800000, 32'hFF800000,
             mk(1'b0, 10'd255, 24'h000000, 3'b011, 1'b0), mk(1'b1, 10'd255, 24'h000000, 3'b011, 1'b0));
    directed("t4", 32'h7FC00000, 32'h7F800001,
             mk(1'b0, 10'd255, 24'h400000, 3'b010, 1'b0), mk(1'b0, 10'd255, 24'h000001, 3'b010, 1'b1));

    // Backpressure: four pairs offered back to back, sink stalled for cycles 3-6.
    for (int i = 0; i < 4; i++) begin
      pa[i] = rand_op();
      pb[i] = rand_op();
    end
    sent      = 0;
    saw_block = 1'b0;
    for (int k = 0; k < 20; k++) begin
      bus.out_ready = !(k >= 3 && k <= 6);
      if (sent < 4) begin
        bus.in_valid = 1'b1;
        bus.a        = pa[sent];
        bus.b        = pb[sent];
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (bus.in_valid && !bus.in_ready) saw_block = 1'b1;
      if (bus.in_valid && bus.in_ready) sent++;
      @(posedge clk);
      #1;
    end
    chk("bp_sent", 64'(sent), 64'(4));
    chk("bp_in_ready_dropped", 64'(saw_block), 64'(1));
    chk("bp_drained", 64'(q.size()), 64'(0));

    // Reset with two pairs held in the pipeline.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.in_valid = 1'b1;
      bus.a        = rand_op();
      bus.b        = rand_op();
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("pre_rst_valid", 64'(bus.out_valid), 64'(1));
    reset_n = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    #1 reset_n = 1'b1;
    bus.out_ready = 1'b1;
    directed("post_rst", 32'h3F800000, 32'h00000001,
             mk(1'b0, 10'd127, 24'h800000, 3'b000, 1'b0), mk(1'b0, 10'h3EA, 24'h800000, 3'b100, 1'b0));

    // Random traffic with random sink stalls; offers are held until taken.
    hold = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!hold) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.a        = rand_op();
        bus.b        = rand_op();
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      hold = bus.in_valid && !bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("final_drain", 64'(q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpu_operand_unpacker.md
Name: fpu_operand_unpacker

Overview:
- Input-side counterpart of the FPU result packer. The packer assembles sign, exponent and fraction from per-field selects.
- This block takes raw IEEE-754 operands A and B apart into sign, extended exponent and normalized significand, and tags each operand with an operand::operand_type class.
- Two-stage elastic pipeline with valid/ready handshakes on both sides. Sits between the FPU issue interface and the arithmetic datapaths.

Parameters:
- EXP_WIDTH, 8, exponent field width.
- FRAC_WIDTH, 23, stored fraction width. Word width W = 1+EXP_WIDTH+FRAC_WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  unpacker accepts this cycle.
- a, b  input  W  raw operands.
- out_valid  output  1  unpacked pair available.
- out_ready  input  1  downstream accepts.
- a_sign, b_sign  output  1  sign bit.
- a_exponent, b_exponent  output  EXP_WIDTH+2  signed, biased, extended exponent.
- a_significand, b_significand  output  FRAC_WIDTH+1  significand with explicit leading bit.
- a_type, b_type  output  3  operand::operand_type class.
- a_snan, b_snan  output  1  operand is a signaling NaN.

Behaviour:
- Reset, asynchronous on reset_n low:
  - both stage-valid flags clear, so out_valid=0;
  - all data output registers clear to 0;
  - in_ready rises combinationally once the stages are empty.
- Reset mid-operation discards any in-flight pairs. No output is produced for them.
- Handshake:
  - A transfer occurs on a rising edge with valid&&ready.
  - out_valid and the output data stay stable while out_valid&&!out_ready.
  - in_ready is independent of in_valid.
- Stage enables:
  - s2_en = !s2_valid || out_ready.
  - s1_en = !s1_valid || s2_en.
  - in_ready = s1_en.
  - Full throughput is one pair per cycle.
  - Latency is 2 cycles from input accept to out_valid when unstalled.
  - Simultaneous accept and drain with both stages full is legal; no bubble is inserted.
- Stage 1, per operand:
  - Split into s, e, f.
  - Classify:
    - e==0 && f==0 -> ZERO (3'b101).
    - e==0 && f!=0 -> SUBNORMAL (3'b100).
    - e==all-ones && f==0 -> INFINITE (3'b011).
    - e==all-ones && f!=0 -> NAN (3'b010).
    - Otherwise NORMAL, always emitted as 3'b000, never 3'b001.
  - snan = NAN && f[FRAC_WIDTH-1]==0.
  - Compute lz = leading-zero count of {1'b0,f} for SUBNORMAL, else 0. Register with class, sign, e and f.
- Stage 2, per operand:
  - NORMAL: exponent = zero-extended e; significand = {1,f}.
  - SUBNORMAL: significand = {1'b0,f} << lz, so the MSB is 1; exponent = 1 - lz as a two's-complement value, range -(FRAC_WIDTH-1)..0.
  - ZERO: exponent = 0; significand = 0.
  - INFINITE / NAN: exponent = zero-extended all-ones (255 by default); significand = {1'b0,f}, which preserves the NaN payload.
  - Sign always passes through unchanged, including for NaN and zero.
- A and B are processed in lockstep and share one valid/ready pair.
- Stage registers load only when their enable is high. No X propagates from idle-cycle inputs into the outputs.

Test Plan:
- Reset, then a=0x3F800000, b=0x00000001 -> after 2 cycles:
  - a: sign 0, exponent 127, significand 0x800000, type 000.
  - b: type 100, significand 0x800000, exponent 10'h3EA (-22).
- a=0x80000000, b=0x007FFFFF -> a: type 101, sign 1, exponent 0, significand 0. b: SUBNORMAL, lz=1, exponent 0, significand 0xFFFFFE.
- a=0x7F800000, b=0xFF800000 -> both type 011, exponent 255, significand 0. Signs 0 and 1.
- a=0x7FC00000, b=0x7F800001 -> both type 010. a_snan=0, b_snan=1. b_significand=0x000001.
- Backpressure: stream 4 pairs with in_valid held high and out_ready=0 for cycles 3-6.
  - in_ready drops once both stages are full.
  - Outputs hold stable while stalled.
  - After release, all 4 pairs emerge in order with none lost or duplicated.
  - Throughput returns to one pair per cycle.
- Assert reset_n low while 2 pairs are in flight -> out_valid=0 immediately, neither pair appears afterward, and the next accepted pair has 2-cycle latency.
